// File: rtl/integrator_decimator.sv
// CIC front half: M chained integrators followed by a 1-in-R strobe selector.
// Optional synchronous flush port enabled by INTEG_SYNC_CLR_EN.
module integrator_decimator #(
  parameter int M       = 1,
  parameter int R       = 4,
  parameter int IN_BITS = 10,
  parameter int BITS    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_BITS-1:0] stream_in,
  input  logic               valid,
`ifdef INTEG_SYNC_CLR_EN
  input  logic               clear,
`endif
  output logic [BITS-1:0]    stream_out,
  output logic               ready
);

  localparam int CW = (R > 1) ? $clog2(R) : 1;

  logic [BITS-1:0] x;
  logic [BITS-1:0] acc     [M];
  logic [BITS-1:0] acc_nxt [M];
  logic [CW-1:0]   cnt;
  logic            last;
  logic            flush;

`ifdef INTEG_SYNC_CLR_EN
  assign flush = clear;
`else
  assign flush = 1'b0;
`endif

  assign x    = BITS'(signed'(stream_in));
  assign last = (cnt == CW'(R - 1));

  // each stage adds the already-updated value of the stage below
  always_comb begin
    logic [BITS-1:0] run;
    run = x;
    for (int m = 0; m < M; m++) begin
      run        = acc[m] + run;
      acc_nxt[m] = run;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int m = 0; m < M; m++) acc[m] <= '0;
      cnt        <= '0;
      stream_out <= '0;
      ready      <= 1'b0;
    end else if (flush) begin
      for (int m = 0; m < M; m++) acc[m] <= '0;
      cnt        <= '0;
      stream_out <= '0;
      ready      <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (valid) begin
        acc <= acc_nxt;
        if (last) begin
          cnt        <= '0;
          stream_out <= acc_nxt[M-1];
          ready      <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_integrator_decimator.sv
// Scoreboard bench: two configurations (M=1/BITS=10, M=2/BITS=12) fed the
// same stream, checked against running-sum reference models.
module tb_integrator_decimator;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic        clr = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  out_a;
  logic        rdy_a;
  logic [11:0] out_b;
  logic        rdy_b;

  always #5 clk = ~clk;

  integrator_decimator #(.M(1), .R(R), .IN_BITS(10), .BITS(10)) dut_a (
    .clk(clk), .rst(rst), .stream_in(x), .valid(valid),
`ifdef INTEG_SYNC_CLR_EN
    .clear(clr),
`endif
    .stream_out(out_a), .ready(rdy_a)
  );

  integrator_decimator #(.M(2), .R(R), .IN_BITS(10), .BITS(12)) dut_b (
    .clk(clk), .rst(rst), .stream_in(x), .valid(valid),
`ifdef INTEG_SYNC_CLR_EN
    .clear(clr),
`endif
    .stream_out(out_b), .ready(rdy_b)
  );

  typedef struct {
    longint v;
    int     t;
  } exp_t;

  exp_t   qa[$];
  exp_t   qb[$];
  int     cyc = 0;
  int     passed = 0;
  int     total = 0;
  longint s1, s2;
  int     n_acc;
  longint hold_a = 0;
  longint hold_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input longint act, input longint req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                  name, act, req, cyc);
  endtask

  // Reference: y1 = running sum of x, y2 = running sum of y1, sampled every R inputs
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 = 0; s2 = 0; n_acc = 0;
      qa.delete(); qb.delete();
      hold_a = 0; hold_b = 0;
    end else if (clr) begin
      s1 = 0; s2 = 0; n_acc = 0;
      hold_a = 0; hold_b = 0;
    end else if (valid) begin
      s1 = (s1 + longint'($signed(x))) & 64'hFFFF;
      s2 = (s2 + s1) & 64'hFFFF;
      n_acc++;
      if (n_acc == R) begin
        n_acc = 0;
        qa.push_back('{v: s1 & 64'h3FF, t: cyc + 1});
        qb.push_back('{v: s2 & 64'hFFF, t: cyc + 1});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check(rdy_a == 0 && out_a == 0, "reset_a", {rdy_a, out_a}, 0);
      check(rdy_b == 0 && out_b == 0, "reset_b", {rdy_b, out_b}, 0);
    end else begin
      while (qa.size() > 0 && qa[0].t < cyc) begin
        e = qa.pop_front();
        check(0, "missed_strobe_a", 0, e.v);
      end
      while (qb.size() > 0 && qb[0].t < cyc) begin
        e = qb.pop_front();
        check(0, "missed_strobe_b", 0, e.v);
      end
      if (rdy_a) begin
        if (qa.size() == 0) begin
          check(0, "spurious_ready_a", out_a, -1);
        end else begin
          e = qa.pop_front();
          check(out_a == 10'(e.v), "data_a", out_a, e.v);
          check(cyc == e.t, "latency_a", cyc, e.t);
          hold_a = e.v;
        end
      end else begin
        check(out_a == 10'(hold_a), "hold_a", out_a, hold_a);
      end
      if (rdy_b) begin
        if (qb.size() == 0) begin
          check(0, "spurious_ready_b", out_b, -1);
        end else begin
          e = qb.pop_front();
          check(out_b == 12'(e.v), "data_b", out_b, e.v);
          check(cyc == e.t, "latency_b", cyc, e.t);
          hold_b = e.v;
        end
      end else begin
        check(out_b == 12'(hold_b), "hold_b", out_b, hold_b);
      end
    end
  end

  task automatic step(input logic v, input logic [9:0] xx, input logic c);
    valid = v;
    x     = xx;
    clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    clr   = 1'b0;
    rst   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // x=1 continuous: A 4,8,12,16; B 10,36,...
    for (int i = 0; i < 16; i++) step(1, 10'd1, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    do_reset();
    for (int i = 0; i < 4; i++) step(1, 10'd511, 0);
    step(0, 0, 0);

    do_reset();
    for (int i = 0; i < 8; i++) step(i % 2 == 0, 10'd2, 0);
    step(0, 0, 0);

    do_reset();
    step(1, 10'd3, 0);
    step(1, 10'd3, 0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 10'd3, 0);
    step(0, 0, 0);

    // reset right after the R-th sample drops the pending strobe
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 10'd9, 0);
    valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    step(0, 0, 0);

`ifdef INTEG_SYNC_CLR_EN
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 10'd5, 0);
    step(1, 10'd7, 1);
    for (int i = 0; i < 4; i++) step(1, 10'd1, 0);
    step(0, 0, 0);
`endif

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic c;
      c = 1'b0;
`ifdef INTEG_SYNC_CLR_EN
      c = ($urandom_range(0, 59) == 0);
`endif
      if ($urandom_range(0, 399) == 0) do_reset();
      step($urandom_range(0, 3) != 0, 10'($urandom), c);
    end
    repeat (3) step(0, 0, 0);

    check(qa.size() == 0, "drain_a", qa.size(), 0);
    check(qb.size() == 0, "drain_b", qb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
